fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: a decoded FP instruction is presented.
REQ-005 SHALL have port in_ready, output, 1: the controller can accept an instruction this cycle.
REQ-006 SHALL have port op_en, input, 10: decoded op enables; bit0..9 = Fadd, Fsub, Fmul, Fdiv, Fsqrt, Fmax, Fmin, Feq, Flt, Fleq.
REQ-007 SHALL have ports rs1, rs2, rd, input, 5 each: decoded register indices.
REQ-008 SHALL have port rd_en, output, 1: register-file read strobe.
REQ-009 SHALL have ports rs1_q and rs2_q, output, 5 each: read addresses, valid while rd_en=1.
REQ-010 SHALL have port unit_start, output, 10: one-hot start pulse to the selected FP unit, same bit order as op_en.
REQ-011 SHALL have port wr_en, output, 1: register-file write strobe.
REQ-012 SHALL have port wr_addr, output, 5: write address, valid while wr_en=1.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have port illegal, output, 1: one-cycle pulse flagging a multi-hot op_en.
REQ-015 SHALL have port op_count, output, CNT_W: number of completed writebacks.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, EXEC and WB.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL accept an instruction when in_ready and in_valid are high and op_en is exactly one-hot, capturing op_en, rs1, rs2 and rd, then moving to READ.
REQ-019 SHALL leave the FSM in IDLE and capture nothing when op_en=0 with in_valid high.
REQ-020 SHALL, for a multi-hot op_en with in_valid high in IDLE, pulse illegal for one cycle, drop the instruction, stay in IDLE and leave op_count unchanged.
REQ-021 SHALL, in READ, hold for exactly 1 cycle with rd_en=1 and rs1_q/rs2_q equal to the captured indices, then move to EXEC.
REQ-022 SHALL, on the first EXEC cycle only, assert unit_start equal to the captured op_en.
REQ-023 SHALL stay in EXEC for L cycles, counted by a down-counter, where L is: add/sub 2, mul 3, div 8, sqrt 8, max/min/eq/lt/leq 1.
REQ-024 SHALL, for L=1, assert unit_start and leave EXEC in the same cycle.
REQ-025 SHALL, in WB, hold for 1 cycle with wr_en=1 and wr_addr equal to the captured rd, increment op_count, then return to IDLE.
REQ-026 SHALL give a total latency from the accept edge of 2+L cycles to the WB cycle, with a throughput of one instruction per 3+L cycles.
REQ-027 SHALL issue Feq/Flt/Fleq writebacks exactly like the other ops.
REQ-028 SHALL ignore rs2 for Fsqrt in function, while still driving it on rs2_q.
REQ-029 SHALL wrap op_count from all-ones to 0 without any flag.
REQ-030 SHALL ignore in_valid while busy; upstream holds the instruction stable until in_ready=1.
REQ-031 SHALL keep rd_en, unit_start and wr_en mutually exclusive in every cycle.

Reset
REQ-032 SHALL, while rst=0, force the FSM to IDLE immediately without waiting for a clock edge.
REQ-033 SHALL, while rst=0, hold every output at 0 except in_ready: rd_en, rs1_q, rs2_q, unit_start, wr_en, wr_addr, busy, illegal, op_count and the latency counter are all 0.
REQ-034 SHALL drive in_ready=1 during reset and immediately after it, since the FSM is in IDLE.
REQ-035 SHALL, on a reset assertion mid-operation, abort the operation with no wr_en and no op_count increment.

Structure
REQ-036 SHALL place the op bit-index constants, the per-op latency constants and the state enumeration in the shared package fpu_pkg.
REQ-037 SHALL contain one sub-module, fpu_lat_lut: combinational, one-hot op in, 4-bit L out, 0 for an invalid op.

Verification
REQ-038 SHALL test Fadd with rs1=17, rs2=10, rd=15 accepted at cycle 0: expect rd_en at cycle 1, unit_start=10'b0000000001 at cycle 2, and wr_en with wr_addr=15 at cycle 4.
REQ-039 SHALL test Fdiv with rd=9 accepted at cycle 0: expect busy for cycles 1-10, unit_start[3] at cycle 2, wr_en at cycle 10, and in_ready=1 again at cycle 11.
REQ-040 SHALL test Feq (L=1) with rd=8: expect start at cycle 2, wr_en at cycle 3, and op_count +1.
REQ-041 SHALL test op_en=10'b0000000011: expect an illegal pulse, no rd_en, and FSM and op_count unchanged.
REQ-042 SHALL test reset driven low at cycle 5 of an Fsqrt: expect outputs 0 with no clock edge required, no wr_en, and a new Fmul accepted right after reset release.
REQ-043 SHALL test op_count preset near wrap (CNT_W=4) followed by 16 back-to-back Fmin: expect op_count to wrap to 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared op bit indices, per-op execute latencies and FSM state codes for the FP issue controller.
package fpu_pkg;

  localparam int OP_W = 10;

  localparam int OP_FADD  = 0;
  localparam int OP_FSUB  = 1;
  localparam int OP_FMUL  = 2;
  localparam int OP_FDIV  = 3;
  localparam int OP_FSQRT = 4;
  localparam int OP_FMAX  = 5;
  localparam int OP_FMIN  = 6;
  localparam int OP_FEQ   = 7;
  localparam int OP_FLT   = 8;
  localparam int OP_FLEQ  = 9;

  localparam logic [OP_W-1:0] OH_FADD  = OP_W'(1) << OP_FADD;
  localparam logic [OP_W-1:0] OH_FSUB  = OP_W'(1) << OP_FSUB;
  localparam logic [OP_W-1:0] OH_FMUL  = OP_W'(1) << OP_FMUL;
  localparam logic [OP_W-1:0] OH_FDIV  = OP_W'(1) << OP_FDIV;
  localparam logic [OP_W-1:0] OH_FSQRT = OP_W'(1) << OP_FSQRT;
  localparam logic [OP_W-1:0] OH_FMAX  = OP_W'(1) << OP_FMAX;
  localparam logic [OP_W-1:0] OH_FMIN  = OP_W'(1) << OP_FMIN;
  localparam logic [OP_W-1:0] OH_FEQ   = OP_W'(1) << OP_FEQ;
  localparam logic [OP_W-1:0] OH_FLT   = OP_W'(1) << OP_FLT;
  localparam logic [OP_W-1:0] OH_FLEQ  = OP_W'(1) << OP_FLEQ;

  localparam logic [3:0] LAT_ADD  = 4'd2;
  localparam logic [3:0] LAT_MUL  = 4'd3;
  localparam logic [3:0] LAT_DIV  = 4'd8;
  localparam logic [3:0] LAT_SQRT = 4'd8;
  localparam logic [3:0] LAT_CMP  = 4'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  function automatic logic is_onehot(input logic [OP_W-1:0] v);
    return (v != '0) && ((v & (v - OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Execute-latency lookup: one-hot op in, cycles in EXEC out; zero for none or multi-hot.
// Purely combinational, no backpressure.
module fpu_lat_lut
  import fpu_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  output logic [3:0]      o_lat
);

  always_comb begin
    o_lat = 4'd0;
    case (i_op)
      OH_FADD, OH_FSUB:                          o_lat = LAT_ADD;
      OH_FMUL:                                   o_lat = LAT_MUL;
      OH_FDIV:                                   o_lat = LAT_DIV;
      OH_FSQRT:                                  o_lat = LAT_SQRT;
      OH_FMAX, OH_FMIN, OH_FEQ, OH_FLT, OH_FLEQ: o_lat = LAT_CMP;
      default:                                   o_lat = 4'd0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue FSM IDLE->READ->EXEC(L)->WB, one instruction in flight; accept->WB latency 2+L.
// in_ready only in IDLE; upstream holds the instruction until accepted.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op_en,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  output logic             rd_en,
  output logic [4:0]       rs1_q,
  output logic [4:0]       rs2_q,
  output logic [OP_W-1:0]  unit_start,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [OP_W-1:0]  r_op;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [3:0]       r_cnt;
  logic             r_first;
  logic             r_illegal;
  logic [CNT_W-1:0] r_op_count;

  logic [3:0]       w_lat;
  logic             w_idle;
  logic             w_multi;

  fpu_lat_lut u_lat (
    .i_op  (r_op),
    .o_lat (w_lat)
  );

  assign w_idle  = (r_state == ST_IDLE);
  assign w_multi = in_valid && (op_en != '0) && !is_onehot(op_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_illegal  <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_illegal <= w_idle && w_multi;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && is_onehot(op_en)) begin
            r_op    <= op_en;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
            r_rd    <= rd;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          // Load L-1 so a count of zero marks the final EXEC cycle.
          r_cnt   <= w_lat - 4'd1;
          r_first <= 1'b1;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_first <= 1'b0;
          if (r_cnt == 4'd0) begin
            r_state <= ST_WB;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WB: begin
          r_op_count <= r_op_count + CNT_ONE;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_idle;
  assign busy       = !w_idle;
  assign rd_en      = (r_state == ST_READ);
  assign rs1_q      = rd_en ? r_rs1 : 5'd0;
  assign rs2_q      = rd_en ? r_rs2 : 5'd0;
  assign unit_start = ((r_state == ST_EXEC) && r_first) ? r_op : '0;
  assign wr_en      = (r_state == ST_WB);
  assign wr_addr    = wr_en ? r_rd : 5'd0;
  assign illegal    = r_illegal;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: timeline model of each instruction checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_fpu_issue_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    op_en = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [4:0]    rd = '0;
  logic          rd_en;
  logic [4:0]    rs1_q;
  logic [4:0]    rs2_q;
  logic [9:0]    unit_start;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic          busy;
  logic          illegal;
  logic [CW-1:0] op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_en      (op_en),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .rd_en      (rd_en),
    .rs1_q      (rs1_q),
    .rs2_q      (rs2_q),
    .unit_start (unit_start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .illegal    (illegal),
    .op_count   (op_count)
  );

  // Model: an accepted instruction is a timeline; age = clock edges since its accept edge.
  int         lat_tab [10] = '{2, 2, 3, 8, 8, 1, 1, 1, 1, 1};
  bit         m_active = 1'b0;
  int         m_age = 0;
  int         m_lat = 0;
  logic [9:0] m_op = '0;
  logic [4:0] m_rs1 = '0;
  logic [4:0] m_rs2 = '0;
  logic [4:0] m_rd = '0;
  int         m_count = 0;
  bit         m_ill = 1'b0;

  function automatic int lat_of(input logic [9:0] op);
    int r = 0;
    for (int i = 0; i < 10; i++) if (op[i]) r = lat_tab[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_count  <= 0;
      m_ill    <= 1'b0;
    end else begin
      m_ill <= 1'b0;
      if (m_active) begin
        m_age <= m_age + 1;
        if (m_age + 1 == 3 + m_lat) begin
          m_active <= 1'b0;
          m_count  <= (m_count + 1) % (1 << CW);
        end
      end else if (in_valid) begin
        if ($countones(op_en) == 1) begin
          m_active <= 1'b1;
          m_age    <= 1;
          m_op     <= op_en;
          m_rs1    <= rs1;
          m_rs2    <= rs2;
          m_rd     <= rd;
          m_lat    <= lat_of(op_en);
        end else if (op_en != '0) begin
          m_ill <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit         e_rd;
    bit         e_wr;
    logic [9:0] e_st;
    e_rd = m_active && (m_age == 1);
    e_wr = m_active && (m_age == 2 + m_lat);
    e_st = (m_active && (m_age == 2)) ? m_op : 10'd0;
    chk("in_ready", 32'(in_ready), 32'(!m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("unit_start", 32'(unit_start), 32'(e_st));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("strobe_excl", 32'($countones({rd_en, |unit_start, wr_en}) <= 1), 32'd1);
    if (e_rd) begin
      chk("rs1_q", 32'(rs1_q), 32'(m_rs1));
      chk("rs2_q", 32'(rs2_q), 32'(m_rs2));
    end
    if (e_wr) chk("wr_addr", 32'(wr_addr), 32'(m_rd));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge (age 1).
  task automatic present(input logic [9:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
    in_valid = 1'b1;
    op_en    = op;
    rs1      = a;
    rs2      = b;
    rd       = d;
    @(negedge clk);
    in_valid = 1'b0;
    op_en    = '0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({nm, "_rs1_q"}, 32'(rs1_q), 32'd0);
    chk({nm, "_rs2_q"}, 32'(rs2_q), 32'd0);
    chk({nm, "_unit_start"}, 32'(unit_start), 32'd0);
    chk({nm, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({nm, "_illegal"}, 32'(illegal), 32'd0);
    chk({nm, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  task automatic run_stimulus();
    #1 chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    cyc(1);

    // Fadd rs1=17 rs2=10 rd=15
    present(10'b0000000001, 5'd17, 5'd10, 5'd15);
    chk("add_rd_en", 32'(rd_en), 32'd1);
    chk("add_rs1_q", 32'(rs1_q), 32'd17);
    chk("add_rs2_q", 32'(rs2_q), 32'd10);
    cyc(1);
    chk("add_start", 32'(unit_start), 32'b0000000001);
    cyc(1);
    chk("add_c3_wr_en", 32'(wr_en), 32'd0);
    cyc(1);
    chk("add_wr_en", 32'(wr_en), 32'd1);
    chk("add_wr_addr", 32'(wr_addr), 32'd15);
    cyc(1);
    chk("add_count", 32'(op_count), 32'd1);
    chk("add_ready", 32'(in_ready), 32'd1);

    // Fdiv rd=9
    present(10'b0000001000, 5'd1, 5'd2, 5'd9);
    chk("div_busy_c1", 32'(busy), 32'd1);
    cyc(1);
    chk("div_start", 32'(unit_start), 32'b0000001000);
    cyc(7);
    chk("div_c9_wr_en", 32'(wr_en), 32'd0);
    chk("div_busy_c9", 32'(busy), 32'd1);
    cyc(1);
    chk("div_wr_en", 32'(wr_en), 32'd1);
    chk("div_wr_addr", 32'(wr_addr), 32'd9);
    chk("div_busy_c10", 32'(busy), 32'd1);
    cyc(1);
    chk("div_ready_c11", 32'(in_ready), 32'd1);
    chk("div_count", 32'(op_count), 32'd2);

    // Feq rd=8, L=1
    present(10'b0010000000, 5'd3, 5'd4, 5'd8);
    cyc(1);
    chk("feq_start", 32'(unit_start), 32'b0010000000);
    cyc(1);
    chk("feq_wr_en", 32'(wr_en), 32'd1);
    chk("feq_wr_addr", 32'(wr_addr), 32'd8);
    cyc(1);
    chk("feq_count", 32'(op_count), 32'd3);

    // op_en zero with valid: nothing happens
    in_valid = 1'b1;
    op_en    = 10'd0;
    cyc(1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_illegal", 32'(illegal), 32'd0);
    in_valid = 1'b0;

    // multi-hot op_en
    in_valid = 1'b1;
    op_en    = 10'b0000000011;
    cyc(1);
    in_valid = 1'b0;
    op_en    = '0;
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_rd_en", 32'(rd_en), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_count", 32'(op_count), 32'd3);
    cyc(1);
    chk("ill_pulse_end", 32'(illegal), 32'd0);

    // Fsqrt aborted by reset at cycle 5, mid-cycle
    present(10'b0000010000, 5'd5, 5'd31, 5'd20);
    cyc(4);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("abort");
    cyc(2);
    rst = 1'b1;

    // Fmul accepted right after release
    present(10'b0000000100, 5'd6, 5'd7, 5'd12);
    chk("mul_rd_en", 32'(rd_en), 32'd1);
    chk("mul_rs1_q", 32'(rs1_q), 32'd6);
    cyc(1);
    chk("mul_start", 32'(unit_start), 32'b0000000100);
    cyc(3);
    chk("mul_wr_en", 32'(wr_en), 32'd1);
    chk("mul_wr_addr", 32'(wr_addr), 32'd12);
    cyc(1);
    chk("mul_count", 32'(op_count), 32'd1);

    // 16 back-to-back Fmin from a count of 1: passes 15 and wraps to 0
    for (int i = 0; i < 16; i++) begin
      present(10'b0001000000, 5'(i), 5'(i), 5'(i));
      cyc(3);
      chk("fmin_count", 32'(op_count), 32'((2 + i) % 16));
      if (i == 14) chk("fmin_wrap_zero", 32'(op_count), 32'd0);
    end
    cyc(2);
  endtask

  initial begin
    #1 rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
      run_stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
